instr_queue: RTL and testbench
==============================

Name: instr_queue

Overview:
- Instruction queue between fetch_unit and dispatch. Each valid fetch (instr, PC, nPC) is buffered in an in-order circular FIFO and presented to dispatch with a valid/ready handshake.
- Supplies the full-based stall that the core controller ORs into core_control_stall_fetch_unit.
- Flushes on ROB restart (from_pipeline_take_resolved).

Parameters:
- IQ_DEPTH, 4, number of entries; must be a power of 2 and at least 2.
- LOG_IQ_DEPTH, 2, log2(IQ_DEPTH); width of the pointers.

Ports:
- CLK  in  1  clock; one clock.
- RST  in  1  reset; synchronous and active-high.
- from_fetch_ivalid  in  1  fetch_unit to_pipeline_ivalid.
- from_fetch_instr  in  32  fetched instruction word.
- from_fetch_PC  in  14  word-granular PC of the instruction.
- from_fetch_nPC  in  14  predicted next PC.
- from_pipeline_take_resolved  in  1  ROB restart; flushes the queue.
- from_dispatch_ready  in  1  dispatch accepts the head entry this cycle.
- to_dispatch_valid  out  1  head entry valid.
- to_dispatch_instr  out  32  head instruction.
- to_dispatch_PC  out  14  head PC.
- to_dispatch_nPC  out  14  head predicted nPC.
- to_dispatch_pred_taken  out  1  head nPC != head PC + 1 (14-bit modular add).
- iq_full  out  1  count == IQ_DEPTH; goes to the core controller as a stall source.
- iq_count  out  LOG_IQ_DEPTH+1  occupancy, 0..IQ_DEPTH.
- DUT_error  out  1  sticky protocol error flag.

Behaviour:
- State: entry array of IQ_DEPTH x {instr, PC, nPC}; head_ptr and tail_ptr; count; DUT_error. All state is registered.
- Reset (RST=1 at a posedge) clears head_ptr, tail_ptr, count, all entries and DUT_error to 0. After reset, every output is 0.
- RST overrides every other input in the same cycle. Asserting RST mid-operation discards all contents.
- enq = from_fetch_ivalid & ~iq_full.
- deq = to_dispatch_valid & from_dispatch_ready.
- to_dispatch_valid = (count != 0).
- Data outputs are driven from entry[head_ptr] at all times. They are don't-care while valid=0, but the bench may check that they equal the slot contents.
- to_dispatch_pred_taken is computed combinationally from the head entry. PC+1 wraps 14'h3FFF -> 14'h0000.
- Enqueue writes entry[tail_ptr] and advances tail_ptr by 1, wrapping modulo IQ_DEPTH.
- Dequeue advances head_ptr by 1, wrapping modulo IQ_DEPTH. The entry contents are not cleared.
- Latency: an entry enqueued in cycle N is visible at the dispatch outputs in cycle N+1 at the earliest. There is no same-cycle bypass from fetch to dispatch.
- Simultaneous enq and deq with 0 < count < IQ_DEPTH: both pointers advance and count is unchanged.
- Empty (count=0): deq is impossible since valid=0. An enq alone sets count to 1.
- Full (count=IQ_DEPTH): iq_full=1 and enq is blocked.
  - iq_full depends only on registered count. A deq in the same cycle does not lower iq_full, so there is no combinational path from ready to stall.
  - The slot freed by that deq becomes usable in the next cycle.
- Flush: from_pipeline_take_resolved=1 sets head_ptr, tail_ptr and count to 0 at the next edge.
  - Flush has priority over enq and deq in the same cycle; both are discarded.
  - Entry contents are retained and not cleared.
  - fetch_unit already masks ivalid during a resolve, so no instruction is lost.
- Protocol error: from_fetch_ivalid=1 while iq_full=1 sets DUT_error=1 at the next edge, except in a flush cycle.
  - The instruction is dropped.
  - DUT_error stays set until RST.
- Ordering: strict FIFO. Entries leave in the exact order they entered, with no reordering or duplication.
- There is no dependency on core_control_halt. Halt drains naturally because fetch stops producing ivalid.

Test Plan:
- Reset, then idle: valid=0, iq_full=0, iq_count=0, DUT_error=0, and all data outputs are 0.
- Single entry: enq instr=32'h8C220004, PC=14'h0010, nPC=14'h0011 with ready=0. Next cycle: valid=1, PC=0010, pred_taken=0, count=1. Then ready=1 -> count=0 the following cycle.
- Fill and wrap: with ready=0, enq 4 entries with PC 1..4 -> iq_full=1, count=4. Apply ivalid=0 and ready=1 for one cycle, then enq PC=5 -> dispatch sees 2,3,4,5 in order and tail_ptr has wrapped to 1.
- Full with deq in the same cycle: count=4, ivalid=1 (error case) and ready=1 -> count=3, the instruction is dropped and DUT_error=1.
- Flush priority: count=3, take_resolved=1 together with ivalid=1 and ready=1 -> next cycle count=0 and valid=0. The following enq of PC=14'h0200 appears as the head.
- Prediction flag: head PC=14'h3FFF, nPC=14'h0000 gives pred_taken=0. Head PC=14'h0020, nPC=14'h0040 gives pred_taken=1.

Source files
------------

// File: rtl/instr_queue.sv
// Instruction queue between fetch and dispatch: in-order circular FIFO of
// {instr, PC, nPC} with a valid/ready dispatch handshake, a registered full
// flag for fetch stall, flush on ROB restart and a sticky overflow error.
module instr_queue #(
   parameter int unsigned IQ_DEPTH     = 4,
   parameter int unsigned LOG_IQ_DEPTH = 2
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    from_fetch_ivalid,
   input  logic [31:0]             from_fetch_instr,
   input  logic [13:0]             from_fetch_PC,
   input  logic [13:0]             from_fetch_nPC,
   input  logic                    from_pipeline_take_resolved,
   input  logic                    from_dispatch_ready,
   output logic                    to_dispatch_valid,
   output logic [31:0]             to_dispatch_instr,
   output logic [13:0]             to_dispatch_PC,
   output logic [13:0]             to_dispatch_nPC,
   output logic                    to_dispatch_pred_taken,
   output logic                    iq_full,
   output logic [LOG_IQ_DEPTH:0]   iq_count,
   output logic                    DUT_error
);

   localparam logic [LOG_IQ_DEPTH:0] FullCount = IQ_DEPTH[LOG_IQ_DEPTH:0];

   logic [31:0]             instr_q [IQ_DEPTH];
   logic [13:0]             pc_q    [IQ_DEPTH];
   logic [13:0]             npc_q   [IQ_DEPTH];
   logic [LOG_IQ_DEPTH-1:0] head_q, head_d;
   logic [LOG_IQ_DEPTH-1:0] tail_q, tail_d;
   logic [LOG_IQ_DEPTH:0]   count_q, count_d;
   logic                    err_q, err_d;

   logic        flush, full, valid, enq, deq;
   logic [13:0] head_pc, head_npc, head_pc_inc;

   // Full depends only on registered count, so ready never reaches the stall.
   assign flush = from_pipeline_take_resolved;
   assign full  = (count_q == FullCount);
   assign valid = (count_q != '0);
   assign enq   = from_fetch_ivalid & ~full;
   assign deq   = valid & from_dispatch_ready;

   // Next-state for pointers, occupancy and the sticky error flag.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      err_d   = err_q | (from_fetch_ivalid & full & ~flush);
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq) tail_d = tail_q + 1'b1;
         if (deq) head_d = head_q + 1'b1;
         case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer, count and error registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // Entry storage; a flush discards the enqueue, dequeue never clears a slot.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < int'(IQ_DEPTH); i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
            npc_q[i]   <= '0;
         end
      end else if (enq && !flush) begin
         instr_q[tail_q] <= from_fetch_instr;
         pc_q[tail_q]    <= from_fetch_PC;
         npc_q[tail_q]   <= from_fetch_nPC;
      end
   end

   assign head_pc     = pc_q[head_q];
   assign head_npc    = npc_q[head_q];
   assign head_pc_inc = head_pc + 14'd1;

   assign to_dispatch_valid      = valid;
   assign to_dispatch_instr      = instr_q[head_q];
   assign to_dispatch_PC         = head_pc;
   assign to_dispatch_nPC        = head_npc;
   // Qualified by valid so an empty queue drives all-zero outputs after reset.
   assign to_dispatch_pred_taken = valid & (head_npc != head_pc_inc);
   assign iq_full                = full;
   assign iq_count               = count_q;
   assign DUT_error              = err_q;

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios plus a randomized
// run, all compared against a slot-array reference model of the queue.
module tb_instr_queue;

   localparam int Depth = 4;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        iv = 1'b0;
   logic [31:0] ins = '0;
   logic [13:0] pc = '0;
   logic [13:0] npc = '0;
   logic        fl = 1'b0;
   logic        rdy = 1'b0;
   logic        valid_o, pred_o, full_o, err_o;
   logic [31:0] instr_o;
   logic [13:0] pc_o, npc_o;
   logic [2:0]  count_o;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: slots indexed by arithmetic position, occupancy as int.
   logic [31:0] m_instr [Depth];
   logic [13:0] m_pc    [Depth];
   logic [13:0] m_npc   [Depth];
   int          m_head, m_tail, m_count;
   bit          m_err;

   always #5 CLK = ~CLK;

   instr_queue #(.IQ_DEPTH(4), .LOG_IQ_DEPTH(2)) dut (
      .CLK                         (CLK),
      .RST                         (RST),
      .from_fetch_ivalid           (iv),
      .from_fetch_instr            (ins),
      .from_fetch_PC               (pc),
      .from_fetch_nPC              (npc),
      .from_pipeline_take_resolved (fl),
      .from_dispatch_ready         (rdy),
      .to_dispatch_valid           (valid_o),
      .to_dispatch_instr           (instr_o),
      .to_dispatch_PC              (pc_o),
      .to_dispatch_nPC             (npc_o),
      .to_dispatch_pred_taken      (pred_o),
      .iq_full                     (full_o),
      .iq_count                    (count_o),
      .DUT_error                   (err_o)
   );

   task automatic model_step();
      bit m_full, m_valid;
      if (RST) begin
         for (int i = 0; i < Depth; i++) begin
            m_instr[i] = '0; m_pc[i] = '0; m_npc[i] = '0;
         end
         m_head = 0; m_tail = 0; m_count = 0; m_err = 0;
      end else begin
         m_full  = (m_count == Depth);
         m_valid = (m_count != 0);
         if (fl) begin
            m_head = 0; m_tail = 0; m_count = 0;
         end else begin
            if (iv && m_full) m_err = 1;
            if (iv && !m_full) begin
               m_instr[m_tail] = ins; m_pc[m_tail] = pc; m_npc[m_tail] = npc;
               m_tail = (m_tail + 1) % Depth;
               m_count++;
            end
            if (m_valid && rdy) begin
               m_head = (m_head + 1) % Depth;
               m_count--;
            end
         end
      end
   endtask

   function automatic bit exp_pred();
      logic [13:0] nxt;
      nxt = m_pc[m_head] + 14'd1;
      return (m_count != 0) && (m_npc[m_head] != nxt);
   endfunction

   function automatic logic [66:0] exp_vec();
      logic [2:0] c;
      c = 3'(m_count);
      return {m_count != 0, m_count == Depth, c, m_err, m_instr[m_head], m_pc[m_head],
              m_npc[m_head], exp_pred()};
   endfunction

   // Drive one cycle's inputs, advance the model at the edge, settle 1 time unit.
   task automatic tick(input bit r, input bit v, input logic [31:0] i, input logic [13:0] p,
                       input logic [13:0] n, input bit f, input bit rd);
      RST = r; iv = v; ins = i; pc = p; npc = n; fl = f; rdy = rd;
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      tick(1, 0, '0, '0, '0, 0, 0);
   endtask

   task automatic enq(input logic [13:0] p, input bit rd);
      logic [13:0] n;
      n = p + 14'd1;
      tick(0, 1, $urandom, p, n, 0, rd);
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count_o); end
      n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", valid_o); end
      n_vec++; if (full_o !== 1'b0) begin n_err++; $display("FAIL reset_full got %0b want 0", full_o); end
      n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL reset_err got %0b want 0", err_o); end
      n_vec++;
      if ({instr_o, pc_o, npc_o, pred_o} !== 61'd0) begin
         n_err++; $display("FAIL reset_data got %h/%h/%h/%b want all 0", instr_o, pc_o, npc_o, pred_o);
      end
      tick(0, 0, '0, '0, '0, 0, 1);
      n_vec++; if (valid_o !== 1'b0 || count_o !== 3'd0) begin
         n_err++; $display("FAIL idle got valid=%0b count=%0d want 0/0", valid_o, count_o);
      end
   endtask

   task automatic test_single();
      do_reset();
      tick(0, 1, 32'h8C220004, 14'h0010, 14'h0011, 0, 0);
      n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL single_valid got %0b want 1", valid_o); end
      n_vec++; if (pc_o !== 14'h0010) begin n_err++; $display("FAIL single_pc got %h want 0010", pc_o); end
      n_vec++; if (instr_o !== 32'h8C220004) begin n_err++; $display("FAIL single_instr got %h want 8c220004", instr_o); end
      n_vec++; if (pred_o !== 1'b0) begin n_err++; $display("FAIL single_pred got %0b want 0", pred_o); end
      n_vec++; if (count_o !== 3'd1) begin n_err++; $display("FAIL single_count got %0d want 1", count_o); end
      tick(0, 0, '0, '0, '0, 0, 1);
      n_vec++; if (count_o !== 3'd0 || valid_o !== 1'b0) begin
         n_err++; $display("FAIL single_deq got count=%0d valid=%0b want 0/0", count_o, valid_o);
      end
   endtask

   task automatic test_fill_wrap();
      logic [13:0] want;
      do_reset();
      for (int k = 1; k <= 4; k++) enq(14'(k), 0);
      n_vec++; if (full_o !== 1'b1 || count_o !== 3'd4) begin
         n_err++; $display("FAIL fill_full got full=%0b count=%0d want 1/4", full_o, count_o);
      end
      tick(0, 0, '0, '0, '0, 0, 1);
      n_vec++; if (count_o !== 3'd3 || full_o !== 1'b0) begin
         n_err++; $display("FAIL fill_deq got count=%0d full=%0b want 3/0", count_o, full_o);
      end
      enq(14'd5, 0);
      for (int k = 0; k < 4; k++) begin
         want = 14'(2 + k);
         n_vec++; if (pc_o !== want || valid_o !== 1'b1) begin
            n_err++; $display("FAIL wrap_order[%0d] got pc=%h valid=%0b want %h/1", k, pc_o, valid_o, want);
         end
         tick(0, 0, '0, '0, '0, 0, 1);
      end
      // Head now sits on slot 1, which still holds PC 2.
      n_vec++; if (count_o !== 3'd0 || pc_o !== 14'h0002) begin
         n_err++; $display("FAIL wrap_drain got count=%0d pc=%h want 0/0002", count_o, pc_o);
      end
      enq(14'd6, 0);
      n_vec++; if (pc_o !== 14'h0006 || count_o !== 3'd1) begin
         n_err++; $display("FAIL wrap_tail got pc=%h count=%0d want 0006/1", pc_o, count_o);
      end
   endtask

   task automatic test_full_deq();
      logic [13:0] want;
      do_reset();
      for (int k = 1; k <= 4; k++) enq(14'h0100 + 14'(k), 0);
      tick(0, 1, 32'hDEADBEEF, 14'h03AA, 14'h03AB, 0, 1);
      n_vec++; if (count_o !== 3'd3 || full_o !== 1'b0) begin
         n_err++; $display("FAIL fulldeq_count got count=%0d full=%0b want 3/0", count_o, full_o);
      end
      n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL fulldeq_err got %0b want 1", err_o); end
      for (int k = 0; k < 3; k++) begin
         want = 14'h0102 + 14'(k);
         n_vec++; if (pc_o !== want) begin
            n_err++; $display("FAIL fulldeq_order[%0d] got %h want %h", k, pc_o, want);
         end
         tick(0, 0, '0, '0, '0, 0, 1);
      end
      n_vec++; if (count_o !== 3'd0 || err_o !== 1'b1) begin
         n_err++; $display("FAIL fulldeq_sticky got count=%0d err=%0b want 0/1", count_o, err_o);
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int k = 1; k <= 3; k++) enq(14'h00A0 + 14'(k), 0);
      tick(0, 1, 32'h12345678, 14'h00AA, 14'h00AB, 1, 1);
      n_vec++; if (count_o !== 3'd0 || valid_o !== 1'b0) begin
         n_err++; $display("FAIL flush_empty got count=%0d valid=%0b want 0/0", count_o, valid_o);
      end
      n_vec++; if (pc_o !== 14'h00A1) begin n_err++; $display("FAIL flush_retain got %h want 00a1", pc_o); end
      enq(14'h0200, 0);
      n_vec++; if (pc_o !== 14'h0200 || count_o !== 3'd1) begin
         n_err++; $display("FAIL flush_enq got pc=%h count=%0d want 0200/1", pc_o, count_o);
      end
      for (int k = 0; k < 3; k++) enq(14'h0300 + 14'(k), 0);
      tick(0, 1, 32'h0, 14'h0400, 14'h0401, 1, 0);
      n_vec++; if (err_o !== 1'b0 || count_o !== 3'd0) begin
         n_err++; $display("FAIL flush_noerr got err=%0b count=%0d want 0/0", err_o, count_o);
      end
   endtask

   task automatic test_pred();
      do_reset();
      tick(0, 1, 32'h1, 14'h3FFF, 14'h0000, 0, 0);
      n_vec++; if (pred_o !== 1'b0 || valid_o !== 1'b1) begin
         n_err++; $display("FAIL pred_wrap got pred=%0b valid=%0b want 0/1", pred_o, valid_o);
      end
      tick(0, 1, 32'h2, 14'h0020, 14'h0040, 0, 1);
      n_vec++; if (pred_o !== 1'b1 || pc_o !== 14'h0020) begin
         n_err++; $display("FAIL pred_taken got pred=%0b pc=%h want 1/0020", pred_o, pc_o);
      end
   endtask

   task automatic test_random();
      logic [66:0] got, want;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         tick(($urandom % 100) == 0, ($urandom % 3) != 0, $urandom, 14'($urandom),
              ($urandom % 2) ? 14'($urandom) : 14'(pc + 14'd1), ($urandom % 25) == 0,
              $urandom % 2);
         got  = {valid_o, full_o, count_o, err_o, instr_o, pc_o, npc_o, pred_o};
         want = exp_vec();
         n_vec++; if (got !== want) begin
            n_err++; $display("FAIL random[%0d] got %h want %h", k, got, want);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_wrap();
      test_full_deq();
      test_flush();
      test_pred();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
